// File: rtl/softmax_row_feeder.sv
// softmax_row_feeder: FIFO-buffered row feeder that max-normalises each row and
// holds it stable on Xi for SOFTMAX_LAT cycles before strobing res_capture.
module softmax_row_feeder #(
   parameter int ARRAYWIDTH  = 4,
   parameter int DATASIZE    = 32,
   parameter int DEPTH       = 4,
   parameter int SOFTMAX_LAT = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [ARRAYWIDTH*DATASIZE-1:0] in_row,
   output logic                           softmax_en,
   output logic [ARRAYWIDTH*DATASIZE-1:0] Xi,
   output logic                           res_capture,
   output logic                           busy,
   output logic [$clog2(DEPTH):0]         fifo_count
);
   localparam int RW = ARRAYWIDTH * DATASIZE;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (SOFTMAX_LAT > 1) ? $clog2(SOFTMAX_LAT) : 1;
   localparam logic [CW-1:0] LAST = CW'(SOFTMAX_LAT - 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [RW-1:0]     mem_q [DEPTH];
   logic [AW-1:0]     wr_q, rd_q;
   logic [AW:0]       count_q, count_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ready_q;
   logic [RW-1:0]     xi_q, xi_d;
   logic [RW-1:0]     head;
   logic [DATASIZE-1:0] mx;
   logic [DATASIZE:0] diff;
   logic              push, pop;

   assign push    = in_valid && ready_q;
   assign pop     = state_q == LOAD;
   assign count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= in_row;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ready_q <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         xi_q    <= '0;
      end else begin
         wr_q    <= wr_q + AW'(push);
         rd_q    <= rd_q + AW'(pop);
         count_q <= count_d;
         ready_q <= count_d != (AW+1)'(DEPTH);
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (pop) xi_q <= xi_d;
      end

   // Differences are computed one bit wider so the negative overflow is visible.
   always_comb begin
      head = mem_q[rd_q];
      mx   = head[DATASIZE-1:0];
      diff = '0;
      xi_d = '0;
      for (int k = 1; k < ARRAYWIDTH; k++)
         if ($signed(head[k*DATASIZE +: DATASIZE]) > $signed(mx)) mx = head[k*DATASIZE +: DATASIZE];
      for (int k = 0; k < ARRAYWIDTH; k++) begin
         diff = {head[k*DATASIZE+DATASIZE-1], head[k*DATASIZE +: DATASIZE]} - {mx[DATASIZE-1], mx};
         xi_d[k*DATASIZE +: DATASIZE] = (diff[DATASIZE] != diff[DATASIZE-1]) ?
            {1'b1, {(DATASIZE-1){1'b0}}} : diff[DATASIZE-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: state_d = (count_q != '0) ? LOAD : IDLE;
         LOAD: begin
            state_d = RUN;
            cnt_d   = '0;
         end
         RUN: begin
            state_d = (cnt_q == LAST) ? DONE : RUN;
            cnt_d   = cnt_q + CW'(1);
         end
         DONE: state_d = (count_q != '0) ? LOAD : IDLE;
      endcase
   end

   assign in_ready    = ready_q;
   assign softmax_en  = (state_q == RUN) || (state_q == DONE);
   assign res_capture = state_q == DONE;
   assign busy        = state_q != IDLE;
   assign Xi          = xi_q;
   assign fifo_count  = count_q;
endmodule

// File: tb/tb_softmax_row_feeder.sv
// tb_softmax_row_feeder: randomized and directed checks of softmax_row_feeder
// against a row-queue / processing-slot reference model.
module tb_softmax_row_feeder;
   localparam int AW = 4, D = 32, DEPTH = 4, LAT = 8, RW = AW * D;

   logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
   logic [RW-1:0] in_row = '0;
   logic          in_ready, softmax_en, res_capture, busy;
   logic [RW-1:0] Xi;
   logic [$clog2(DEPTH):0] fifo_count;

   softmax_row_feeder #(.ARRAYWIDTH(AW), .DATASIZE(D), .DEPTH(DEPTH), .SOFTMAX_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
      .softmax_en(softmax_en), .Xi(Xi), .res_capture(res_capture), .busy(busy),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int checks = 0, passed = 0, fails = 0, cyc = 0;
   // pos: -1 idle, 0 load cycle, 1..LAT run cycles, LAT+1 done cycle
   int pos = -1;
   logic [RW-1:0] q[$];
   logic [RW-1:0] exp_xi = '0;
   int caps[$];

   function automatic logic [RW-1:0] ref_xi(input logic [RW-1:0] r);
      longint e[AW];
      longint mx, d;
      logic [RW-1:0] res;
      res = '0;
      for (int k = 0; k < AW; k++) e[k] = longint'($signed(r[k*D +: D]));
      mx = e[0];
      for (int k = 1; k < AW; k++) if (e[k] > mx) mx = e[k];
      for (int k = 0; k < AW; k++) begin
         d = e[k] - mx;
         if (d < -(longint'(1) <<< (D-1))) d = -(longint'(1) <<< (D-1));
         res[k*D +: D] = D'(d);
      end
      return res;
   endfunction

   function automatic logic [RW-1:0] rand_row();
      logic [RW-1:0] r;
      logic [D-1:0] v;
      for (int k = 0; k < AW; k++) begin
         v = $urandom;
         if (v[0]) v = {{(D-8){v[31]}}, v[31:24]};
         r[k*D +: D] = v;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("Xi", Xi, exp_xi);
      chk("softmax_en", softmax_en, pos >= 1);
      chk("res_capture", res_capture, pos == LAT + 1);
      chk("busy", busy, pos >= 0);
      chk("fifo_count", fifo_count, q.size());
      chk("in_ready", in_ready, q.size() < DEPTH);
   endtask

   task automatic tick();
      int n;
      bit push, pop;
      logic [RW-1:0] row;
      n = q.size();
      push = in_valid && (n < DEPTH);
      pop = pos == 0;
      row = in_row;
      @(posedge clk);
      #1;
      cyc++;
      if (pop) exp_xi = ref_xi(q.pop_front());
      if (push) q.push_back(row);
      pos = (pos == -1 || pos == LAT + 1) ? ((n != 0) ? 0 : -1) : pos + 1;
      if (res_capture) caps.push_back(cyc);
      check_all();
   endtask

   task automatic push_row(input logic [RW-1:0] r);
      in_valid = 1'b1;
      in_row = r;
      tick();
      in_valid = 1'b0;
      in_row = rand_row();
   endtask

   initial begin
      int p, cap_at, en_cnt, accepted;
      bit saw_full;
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // single row: value, enable window and latency
      push_row(128'h00000001_00000002_00000003_00000004);
      p = cyc; cap_at = -1; en_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (softmax_en) en_cnt++;
         if (res_capture && cap_at < 0) cap_at = cyc;
      end
      chk("t1_xi", Xi, 128'hFFFFFFFD_FFFFFFFE_FFFFFFFF_00000000);
      chk("t1_en_cycles", en_cnt, LAT + 1);
      chk("t1_latency", cap_at - p + 1, LAT + 3);

      // equal elements and saturation
      push_row({4{32'h00000007}});
      repeat (30) tick();
      chk("t2_equal", Xi, '0);
      push_row(128'h7FFFFFFF_80000000_00000000_00000000);
      repeat (30) tick();
      chk("t2_sat", Xi, 128'h00000000_80000000_80000001_80000001);

      // back-to-back rows past FIFO capacity
      caps.delete();
      saw_full = 0;
      accepted = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         in_valid = 1'b1;
         in_row = rand_row();
         for (int w = 0; w < 100 && q.size() >= DEPTH; w++) begin
            if (!in_ready) saw_full = 1;
            tick();
         end
         tick();
         accepted++;
      end
      in_valid = 1'b0;
      repeat ((DEPTH + 3) * (LAT + 2)) tick();
      chk("t3_ready_dropped", saw_full, 1);
      chk("t3_captures", caps.size(), accepted);
      for (int i = 1; i < caps.size(); i++) chk("t3_interval", caps[i] - caps[i-1], LAT + 2);

      // random traffic: simultaneous push/pop and pointer wrap
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 2) == 0);
         in_row = rand_row();
         tick();
      end
      in_valid = 1'b0;
      repeat ((DEPTH + 2) * (LAT + 2)) tick();

      // async reset mid-run with two rows queued
      for (int i = 0; i < 3; i++) push_row(rand_row());
      repeat (2) tick();
      chk("t5_queued", fifo_count, 2);
      #2 rst = 1'b1;
      #1;
      chk("t5_en", softmax_en, 0);
      chk("t5_count", fifo_count, 0);
      chk("t5_busy", busy, 0);
      chk("t5_cap", res_capture, 0);
      chk("t5_xi", Xi, '0);
      chk("t5_ready", in_ready, 1);
      q.delete();
      pos = -1;
      exp_xi = '0;
      #1 rst = 1'b0;
      push_row(128'h00000010_00000000_FFFFFFF0_00000005);
      repeat (30) tick();
      chk("t5_restart", Xi, 128'h00000000_FFFFFFF0_FFFFFFE0_FFFFFFF5);

      // idle with garbage and in_valid low
      for (int i = 0; i < 20; i++) begin
         in_row = rand_row();
         tick();
      end
      chk("t6_busy", busy, 0);
      chk("t6_en", softmax_en, 0);
      chk("t6_count", fifo_count, 0);

      if (fails != 0) $display("%0d comparisons did not match", fails);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
